// File: rtl/pipe_reg_mux_n.sv
// pipe_reg_mux_n: stallable, flushable, valid-tracked register pipeline of DEPTH stages (0 = bypass).
// Optional per-stage parity with a sticky error flag is compiled in by defining PIPE_PARITY_EN.
module pipe_reg_mux_n #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 1,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  input  logic             inj_par_err,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             busy,
  output logic             par_err
);

  function automatic logic calc_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  if (DEPTH == 0) begin : g_bypass
    assign b        = a;
    assign b_valid  = a_valid;
    assign fill_cnt = {CNT_W{1'b0}};
    assign busy     = 1'b0;

`ifdef PIPE_PARITY_EN
    logic par_err_q;
    logic par_err_d;
    logic unused_s;

    // Sticky flag: a valid word presented with the injection bit set.
    always_comb begin
      par_err_d = par_err_q;
      if (a_valid && inj_par_err) begin
        par_err_d = 1'b1;
      end else begin
        par_err_d = par_err_q;
      end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        par_err_q <= 1'b0;
      end else begin
        par_err_q <= par_err_d;
      end
    end

    assign par_err  = par_err_q;
    assign unused_s = ^{clken, flush};
`else
    logic unused_s;
    assign par_err  = 1'b0;
    assign unused_s = ^{clk, clken, flush, inj_par_err};
`endif
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic             busy_q;

    // Next-state: flush wins over advance; otherwise hold.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      fill_d  = fill_q;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = {WIDTH{1'b0}};
        end
        valid_d = {DEPTH{1'b0}};
        fill_d  = {CNT_W{1'b0}};
      end else if (clken) begin
        data_d[0]  = a;
        valid_d[0] = a_valid;
        for (int i = 1; i < DEPTH; i++) begin
          data_d[i]  = data_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
        // Entry and exit in the same cycle cancel out.
        fill_d = fill_q + CNT_W'(a_valid) - CNT_W'(valid_q[DEPTH-1]);
      end else begin
        fill_d = fill_q;
      end
    end

    // Stage data, valid bits and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= {WIDTH{1'b0}};
        end
        valid_q <= {DEPTH{1'b0}};
        fill_q  <= {CNT_W{1'b0}};
        busy_q  <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        fill_q  <= fill_d;
        busy_q  <= (fill_d != {CNT_W{1'b0}});
      end
    end

    assign b        = data_q[DEPTH-1];
    assign b_valid  = valid_q[DEPTH-1];
    assign fill_cnt = fill_q;
    assign busy     = busy_q;

`ifdef PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_d;
    logic             par_err_q;
    logic             par_err_d;
    logic             err_hit_s;

    assign err_hit_s = valid_q[DEPTH-1] && (calc_par(data_q[DEPTH-1]) != par_q[DEPTH-1]);

    // Parity bits follow the same flush/advance/hold rules as the data.
    always_comb begin
      par_d     = par_q;
      par_err_d = par_err_q | err_hit_s;
      if (flush) begin
        par_d = {DEPTH{1'b0}};
      end else if (clken) begin
        par_d[0] = calc_par(a) ^ inj_par_err;
        for (int i = 1; i < DEPTH; i++) begin
          par_d[i] = par_q[i-1];
        end
      end else begin
        par_d = par_q;
      end
    end

    // Parity storage and sticky error flag; flush does not clear the flag.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        par_q     <= {DEPTH{1'b0}};
        par_err_q <= 1'b0;
      end else begin
        par_q     <= par_d;
        par_err_q <= par_err_d;
      end
    end

    assign par_err = par_err_q;
`else
    logic unused_s;
    assign par_err  = 1'b0;
    assign unused_s = inj_par_err;
`endif
  end

endmodule
